pwm_sequencer: RTL
==================

# pwm_sequencer

Startup/shutdown and protection sequencer for the open-loop SMPS power stage. Sits between the user switches/comparators and the DPWM and its dead-time selectors. Outputs: DPWM enable, an 8-bit duty-select code ramped at a controlled rate, and latched dead-time selects. Replaces free-running soft start with a single state machine that owns enable, ramp-up, retargeting, ramp-down and over-current shutdown.

## Interface
- STEP_CYCLES, 2000: clk cycles between duty steps (≥1)
- DUTY_STEP, 1: duty-code increment/decrement per step (1..255)
- DUTY_MIN, 0: duty code at enable and at ramp-down end
- OCP_FILT, 4: consecutive high samples of i_ocp that declare a fault (≥1)

- clk  in  1  PLL 200 MHz clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  level; begin start-up when in IDLE
- i_stop  in  1  level; begin ramp-down when in RAMP/RUN
- i_load  in  1  pulse; accept new i_target_duty while in RAMP/RUN
- i_target_duty  in  8  requested duty-select code
- i_sw_dt1, i_sw_dt2  in  4 each  dead-time selects, latched at start
- i_ocp  in  1  over-current comparator, pre-synchronised
- i_fault_clr  in  1  clears latched fault
- o_dpwm_en  out  1  DPWM enable
- o_duty_sel  out  8  duty-select code to the duty mux
- o_dt1, o_dt2  out  4 each  latched dead-time selects to the dt muxes
- o_state  out  3  current state encoding
- o_done  out  1  high in RUN only
- o_fault  out  1  latched fault flag

## Operation
- States: IDLE=0, RAMP=1, RUN=2, STOP=3, FAULT=4; 5–7 unreachable, decode to IDLE.
- Reset: state IDLE, o_dpwm_en=0, o_duty_sel=0, o_dt1=o_dt2=0, o_done=0, o_fault=0, tgt=0, tick and OCP counters 0.
- IDLE: i_start=1 → latch tgt=i_target_duty and dt selects, duty=DUTY_MIN, en=1. If tgt==DUTY_MIN → RUN, else RAMP.
- RAMP: tick counter counts 0..STEP_CYCLES-1, cleared on entry to RAMP/STOP and on every accepted i_load. Each tick moves duty toward tgt by DUTY_STEP, saturating at tgt (9-bit intermediate, no wrap past 0 or 255). Duty reaching tgt → RUN on the same edge.
- RUN: duty held. i_load with i_target_duty≠duty → latch tgt, go RAMP. Equal value → stay.
- i_load in RAMP: latch new tgt; direction re-evaluated at the next tick.
- i_stop in RAMP/RUN → STOP (beats i_load on the same cycle). STOP ramps toward DUTY_MIN using the same tick/step rules. Reaching DUTY_MIN → en=0, duty=0, IDLE. i_start ignored in STOP.
- OCP: counter increments while i_ocp=1 and clears when i_ocp=0. Reaching OCP_FILT in any state except IDLE/FAULT → FAULT, en=0, duty=0, o_fault=1. Highest priority of all events.
- FAULT: hold outputs off. i_fault_clr=1 and i_ocp=0 → IDLE, o_fault=0. i_start ignored until then.
- Dead-time selects change only on the IDLE→start edge. Held through FAULT.

## Timing
- All outputs registered. Input sampled at edge k → output changes after edge k.
- Start: duty=DUTY_MIN and en=1 after the start edge. First step STEP_CYCLES edges later.
- Ramp 0→N: ceil(|N−DUTY_MIN|/DUTY_STEP)·STEP_CYCLES cycles from start to o_done.
- OCP: en drops OCP_FILT edges after i_ocp rises (single cycle of filtering per sample).
- Async reset forces en=0 immediately, not clock-gated.
- Simultaneous i_start and i_stop in IDLE: start wins. i_stop is evaluated from the next cycle on.

## Structure
- smps_pkg: state enum (3-bit) and default parameter constants, shared with dpwm/soft_start consumers.
- One sub-module, ramp_tick: STEP_CYCLES prescaler with sync clear, outputs a 1-cycle tick.
- Sequencer FSM, saturating duty arithmetic and OCP filter live in pwm_sequencer.

## Test plan
- STEP_CYCLES=4, DUTY_STEP=8, DUTY_MIN=16, target 64, start: duty 16,24,…,64, changing every 4 cycles. o_done at cycle 24, en=1 throughout.
- Same setup, i_load target 40 in RUN: duty 56,48,40 at 4-cycle spacing, then RUN. Target 250 with step 8 saturates at 250, no wrap.
- i_stop in RUN at duty 64: ramps to 16, then en=0, duty=0, IDLE. i_stop and i_load in the same cycle: stop wins.
- OCP_FILT=4: i_ocp high 3 cycles: no fault. High 4 cycles mid-RAMP: en=0, o_fault=1, state 4. i_start ignored. i_fault_clr with i_ocp=0 → IDLE.
- i_sw_dt1=5 at start, changed to 9 during RUN: o_dt1 stays 5 until the next start.
- Reset asserted mid-RAMP: all outputs 0 asynchronously. After release, IDLE, with no output change until i_start.

Source files
------------

// File: rtl/smps_pkg.sv
// rtl/smps_pkg.sv - shared state encoding, default constants and duty-step helper for the SMPS stage
package smps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } seq_state_t;

  localparam int STEP_CYCLES_DEF = 2000;
  localparam int DUTY_STEP_DEF   = 1;
  localparam int DUTY_MIN_DEF    = 0;
  localparam int OCP_FILT_DEF    = 4;

  // One step of duty toward tgt; 9-bit math so the code clamps at tgt instead of wrapping.
  function automatic logic [7:0] duty_toward(input logic [7:0] duty,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [8:0] up;
    logic [8:0] dn;
    logic [7:0] res;
    up = {1'b0, duty} + {1'b0, step};
    dn = {1'b0, duty} - {1'b0, step};
    if (duty < tgt) begin
      res = (up >= {1'b0, tgt}) ? tgt : up[7:0];
    end else if (duty > tgt) begin
      res = (dn[8] || (dn[7:0] <= tgt)) ? tgt : dn[7:0];
    end else begin
      res = tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_sequencer_if.sv
// rtl/pwm_sequencer_if.sv - control/status bundle between the switch/comparator side and the sequencer
interface pwm_sequencer_if;
  logic       i_start;
  logic       i_stop;
  logic       i_load;
  logic [7:0] i_target_duty;
  logic [3:0] i_sw_dt1;
  logic [3:0] i_sw_dt2;
  logic       i_ocp;
  logic       i_fault_clr;
  logic       o_dpwm_en;
  logic [7:0] o_duty_sel;
  logic [3:0] o_dt1;
  logic [3:0] o_dt2;
  logic [2:0] o_state;
  logic       o_done;
  logic       o_fault;

  modport master (
    output i_start, i_stop, i_load, i_target_duty, i_sw_dt1, i_sw_dt2, i_ocp, i_fault_clr,
    input  o_dpwm_en, o_duty_sel, o_dt1, o_dt2, o_state, o_done, o_fault
  );

  modport slave (
    input  i_start, i_stop, i_load, i_target_duty, i_sw_dt1, i_sw_dt2, i_ocp, i_fault_clr,
    output o_dpwm_en, o_duty_sel, o_dt1, o_dt2, o_state, o_done, o_fault
  );
endinterface

// File: rtl/ramp_tick.sv
// rtl/ramp_tick.sv - STEP_CYCLES prescaler with synchronous clear producing a one-cycle step tick
module ramp_tick #(
  parameter int STEP_CYCLES = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// rtl/pwm_sequencer.sv - start-up/shutdown/OCP sequencer owning DPWM enable, duty ramp and dead-time latch
module pwm_sequencer
  import smps_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int DUTY_STEP   = DUTY_STEP_DEF,
  parameter int DUTY_MIN    = DUTY_MIN_DEF,
  parameter int OCP_FILT    = OCP_FILT_DEF
) (
  input logic           clk,
  input logic           rst,
  pwm_sequencer_if.slave bus
);

  localparam logic [7:0] STEP8 = 8'(DUTY_STEP);
  localparam logic [7:0] MIN8  = 8'(DUTY_MIN);
  localparam int         OCW   = $clog2(OCP_FILT + 1);
  localparam logic [OCW-1:0] OCP_LAST = OCW'(OCP_FILT - 1);
  localparam logic [OCW-1:0] OCP_MAX  = OCW'(OCP_FILT);

  seq_state_t state_q, state_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] tgt_q, tgt_d;
  logic [3:0] dt1_q, dt1_d;
  logic [3:0] dt2_q, dt2_d;
  logic       en_q, en_d;
  logic       fault_q, fault_d;
  logic       done_q, done_d;
  logic [OCW-1:0] ocp_cnt_q;
  logic       ocp_trip;
  logic       active;
  logic       tick_clr;
  logic       tick_en;
  logic       tick;
  logic [7:0] step_val;

  ramp_tick #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  assign tick_en  = (state_q == ST_RAMP) || (state_q == ST_STOP);
  assign active   = (state_q == ST_RAMP) || (state_q == ST_RUN) || (state_q == ST_STOP);
  // Trip on the sample that completes OCP_FILT consecutive highs, so en drops on that edge.
  assign ocp_trip = bus.i_ocp && (ocp_cnt_q >= OCP_LAST);
  assign step_val = duty_toward(duty_q, (state_q == ST_STOP) ? MIN8 : tgt_q, STEP8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ocp_cnt_q <= '0;
    end else if (!bus.i_ocp) begin
      ocp_cnt_q <= '0;
    end else if (ocp_cnt_q != OCP_MAX) begin
      ocp_cnt_q <= ocp_cnt_q + OCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      dt1_q   <= '0;
      dt2_q   <= '0;
      en_q    <= 1'b0;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      dt1_q   <= dt1_d;
      dt2_q   <= dt2_d;
      en_q    <= en_d;
      fault_q <= fault_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    tgt_d    = tgt_q;
    dt1_d    = dt1_q;
    dt2_d    = dt2_q;
    en_d     = en_q;
    fault_d  = fault_q;
    tick_clr = 1'b0;

    case (state_q)
      ST_RAMP: begin
        if (bus.i_stop) begin
          state_d  = ST_STOP;
          tick_clr = 1'b1;
        end else if (bus.i_load) begin
          tgt_d    = bus.i_target_duty;
          tick_clr = 1'b1;
        end else if (tick) begin
          duty_d = step_val;
          if (step_val == tgt_q) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (bus.i_stop) begin
          state_d  = ST_STOP;
          tick_clr = 1'b1;
        end else if (bus.i_load && (bus.i_target_duty != duty_q)) begin
          tgt_d    = bus.i_target_duty;
          state_d  = ST_RAMP;
          tick_clr = 1'b1;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (step_val == MIN8) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            duty_d  = '0;
          end else begin
            duty_d = step_val;
          end
        end
      end

      ST_FAULT: begin
        en_d   = 1'b0;
        duty_d = '0;
        if (bus.i_fault_clr && !bus.i_ocp) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end

      // IDLE, and the unused encodings 5..7 which behave as IDLE.
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        duty_d  = '0;
        fault_d = 1'b0;
        if (bus.i_start) begin
          tgt_d    = bus.i_target_duty;
          dt1_d    = bus.i_sw_dt1;
          dt2_d    = bus.i_sw_dt2;
          duty_d   = MIN8;
          en_d     = 1'b1;
          tick_clr = 1'b1;
          state_d  = (bus.i_target_duty == MIN8) ? ST_RUN : ST_RAMP;
        end
      end
    endcase

    if (ocp_trip && active) begin
      state_d = ST_FAULT;
      en_d    = 1'b0;
      duty_d  = '0;
      fault_d = 1'b1;
    end

    done_d = (state_d == ST_RUN);
  end

  assign bus.o_dpwm_en  = en_q;
  assign bus.o_duty_sel = duty_q;
  assign bus.o_dt1      = dt1_q;
  assign bus.o_dt2      = dt2_q;
  assign bus.o_state    = state_q;
  assign bus.o_done     = done_q;
  assign bus.o_fault    = fault_q;

endmodule
